// File: rtl/ds18b20_poll_sequencer_if.sv
// ds18b20_poll_sequencer_if: request/done handshake to the byte-level 1-wire engine
`timescale 1ns/1ps
interface ds18b20_poll_sequencer_if;
    logic       op_req;
    logic [1:0] op_code;
    logic [7:0] op_wdata;
    logic       op_done;
    logic       op_presence;
    logic [7:0] op_rdata;
    modport master(output op_req, op_code, op_wdata, input op_done, op_presence, op_rdata);
    modport slave(input op_req, op_code, op_wdata, output op_done, op_presence, op_rdata);
endinterface

// File: rtl/ds18b20_poll_sequencer.sv
// ds18b20_poll_sequencer: round-robin convert/read scheduler for DS18B20 sensors on one 1-wire bus
`timescale 1ns/1ps
module ds18b20_poll_sequencer #(
    parameter int NUM_DEV       = 4,
    parameter int DEV_W         = 3,
    parameter int CONV_WAIT_US  = 750000,
    parameter int OP_TIMEOUT_US = 10000
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   f1m,
    input  logic                   enable,
    ds18b20_poll_sequencer_if.master bus,
    output logic [DEV_W-1:0]       device,
    output logic [2:0]             addr_idx,
    input  logic [7:0]             addr_byte,
    output logic [15:0]            temp_data,
    output logic [DEV_W-1:0]       temp_dev,
    output logic                   temp_valid,
    output logic                   crc_err,
    output logic                   no_presence,
    output logic                   bus_fault
);
    localparam int CW = $clog2((CONV_WAIT_US > OP_TIMEOUT_US ? CONV_WAIT_US : OP_TIMEOUT_US) + 1);

    typedef enum logic [3:0] {
        IDLE, RST1, MROM1, ADDR1, CONV, WAIT, RST2, MROM2, ADDR2, RDCMD, RDATA, REPORT, NEXT
    } state_t;

    state_t state, state_n;
    logic busy, busy_n, req_n, tv_n, ce_n, np_n, bf_n, is_op;
    logic [1:0] code_n;
    logic [7:0] wdata_n, crc, crc_n, lsb, lsb_n, msb, msb_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [3:0] rcnt, rcnt_n;
    logic [DEV_W-1:0] dev_n, tdev_n;
    logic [2:0] idx_n;
    logic [15:0] tdata_n;

    function automatic logic [7:0] crc8(input logic [7:0] c, input logic [7:0] d);
        logic [7:0] x;
        x = c ^ d;
        for (int i = 0; i < 8; i++) x = x[0] ? ((x >> 1) ^ 8'h8C) : (x >> 1);
        return x;
    endfunction

    assign is_op = state inside {RST1, MROM1, ADDR1, CONV, RST2, MROM2, ADDR2, RDCMD, RDATA};

    // Next-state and output decode; an op state issues one request, then waits for done or timeout
    always_comb begin
        state_n = state;
        busy_n  = busy;
        req_n   = 1'b0;
        code_n  = bus.op_code;
        wdata_n = bus.op_wdata;
        cnt_n   = cnt;
        rcnt_n  = rcnt;
        crc_n   = crc;
        lsb_n   = lsb;
        msb_n   = msb;
        dev_n   = device;
        idx_n   = addr_idx;
        tdata_n = temp_data;
        tdev_n  = temp_dev;
        tv_n    = 1'b0;
        ce_n    = 1'b0;
        np_n    = 1'b0;
        bf_n    = 1'b0;
        if (is_op && !busy) begin
            req_n   = 1'b1;
            busy_n  = 1'b1;
            cnt_n   = '0;
            code_n  = (state == RST1 || state == RST2) ? 2'b00 : (state == RDATA) ? 2'b10 : 2'b01;
            wdata_n = (state == MROM1 || state == MROM2) ? 8'h55 :
                      (state == CONV) ? 8'h44 :
                      (state == RDCMD) ? 8'hBE :
                      (state == ADDR1 || state == ADDR2) ? addr_byte : bus.op_wdata;
        end else if (busy && bus.op_done) begin
            busy_n = 1'b0;
            cnt_n  = '0;
            case (state)
                RST1, RST2: begin
                    if (bus.op_presence) state_n = (state == RST1) ? MROM1 : MROM2;
                    else begin
                        np_n    = 1'b1;
                        state_n = NEXT;
                    end
                end
                MROM1: state_n = ADDR1;
                MROM2: state_n = ADDR2;
                ADDR1, ADDR2: begin
                    idx_n = addr_idx + 1'b1;
                    if (addr_idx == 3'd7) state_n = (state == ADDR1) ? CONV : RDCMD;
                end
                CONV: state_n = WAIT;
                RDCMD: begin
                    state_n = RDATA;
                    rcnt_n  = '0;
                    crc_n   = '0;
                end
                RDATA: begin
                    crc_n  = crc8(crc, bus.op_rdata);
                    rcnt_n = rcnt + 1'b1;
                    if (rcnt == 4'd0) lsb_n = bus.op_rdata;
                    if (rcnt == 4'd1) msb_n = bus.op_rdata;
                    if (rcnt == 4'd8) state_n = REPORT;
                end
                default: ;
            endcase
        end else if (busy && f1m) begin
            if (cnt == CW'(OP_TIMEOUT_US - 1)) begin
                bf_n    = 1'b1;
                busy_n  = 1'b0;
                idx_n   = '0;
                state_n = NEXT;
            end else cnt_n = cnt + 1'b1;
        end else begin
            case (state)
                IDLE: if (enable) state_n = RST1;
                WAIT: begin
                    if (f1m) begin
                        cnt_n   = (cnt == CW'(CONV_WAIT_US - 1)) ? '0 : cnt + 1'b1;
                        state_n = (cnt == CW'(CONV_WAIT_US - 1)) ? RST2 : WAIT;
                    end
                end
                REPORT: begin
                    state_n = NEXT;
                    tv_n    = (crc == 8'h00);
                    ce_n    = (crc != 8'h00);
                    tdata_n = (crc == 8'h00) ? {msb, lsb} : temp_data;
                    tdev_n  = (crc == 8'h00) ? device : temp_dev;
                end
                NEXT: begin
                    dev_n   = (device == DEV_W'(NUM_DEV - 1)) ? '0 : device + 1'b1;
                    state_n = IDLE;
                end
                default: ;
            endcase
        end
    end

    // State, handshake and result registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            busy         <= 1'b0;
            bus.op_req   <= 1'b0;
            bus.op_code  <= 2'b00;
            bus.op_wdata <= 8'h00;
            cnt          <= '0;
            rcnt         <= '0;
            crc          <= '0;
            lsb          <= '0;
            msb          <= '0;
            device       <= '0;
            addr_idx     <= '0;
            temp_data    <= '0;
            temp_dev     <= '0;
            temp_valid   <= 1'b0;
            crc_err      <= 1'b0;
            no_presence  <= 1'b0;
            bus_fault    <= 1'b0;
        end else begin
            state        <= state_n;
            busy         <= busy_n;
            bus.op_req   <= req_n;
            bus.op_code  <= code_n;
            bus.op_wdata <= wdata_n;
            cnt          <= cnt_n;
            rcnt         <= rcnt_n;
            crc          <= crc_n;
            lsb          <= lsb_n;
            msb          <= msb_n;
            device       <= dev_n;
            addr_idx     <= idx_n;
            temp_data    <= tdata_n;
            temp_dev     <= tdev_n;
            temp_valid   <= tv_n;
            crc_err      <= ce_n;
            no_presence  <= np_n;
            bus_fault    <= bf_n;
        end
    end
endmodule

// File: tb/tb_ds18b20_poll_sequencer.sv
// tb_ds18b20_poll_sequencer: randomized engine model with op and outcome scoreboards
`timescale 1ns/1ps
module tb_ds18b20_poll_sequencer;
    localparam int NDEV = 4;
    localparam int CWU  = 20;
    localparam int TOU  = 30;

    typedef struct {
        int          kind;
        int          dev;
        logic [15:0] temp;
    } ev_t;

    logic clk = 1'b0, rst_n = 1'b0, f1m = 1'b0, enable = 1'b0;
    logic [2:0] device, temp_dev, addr_idx;
    logic [7:0] addr_byte;
    logic [15:0] temp_data;
    logic temp_valid, crc_err, no_presence, bus_fault;
    logic [7:0] rom [8][8];
    logic [7:0] sp [9];
    logic [9:0] opq [$];
    ev_t outq [$];
    int nvec = 0, nbad = 0, opn = 0, np_idx = -1, hang_idx = -1, rst_idx = -1, mdev = 0;
    logic [15:0] mlast = 16'h0000;
    bit rst_hit = 0, pend = 0;

    ds18b20_poll_sequencer_if bus();

    ds18b20_poll_sequencer #(.NUM_DEV(NDEV), .DEV_W(3), .CONV_WAIT_US(CWU), .OP_TIMEOUT_US(TOU)) dut (
        .clk(clk), .rst_n(rst_n), .f1m(f1m), .enable(enable), .bus(bus),
        .device(device), .addr_idx(addr_idx), .addr_byte(addr_byte),
        .temp_data(temp_data), .temp_dev(temp_dev), .temp_valid(temp_valid),
        .crc_err(crc_err), .no_presence(no_presence), .bus_fault(bus_fault)
    );

    assign addr_byte = rom[device][addr_idx];

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nbad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic finish_now();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
        $finish;
    endtask

    // Dallas CRC-8 computed bit by bit over the first n bytes of the scratchpad
    function automatic logic [7:0] crc_of(input int n);
        logic [7:0] c;
        logic fb;
        c = 8'h00;
        for (int i = 0; i < n; i++)
            for (int j = 0; j < 8; j++) begin
                fb = c[0] ^ sp[i][j];
                c  = c >> 1;
                if (fb) c = c ^ 8'h8C;
            end
        return c;
    endfunction

    // 1 MHz strobe: single-cycle pulses, never on adjacent clocks
    initial forever begin
        @(posedge clk); #1 f1m = 1'b1;
        @(posedge clk); #1 f1m = 1'b0;
        repeat ($urandom_range(0, 2)) @(posedge clk);
    end

    // Byte engine model: checks each request against the expected op stream and answers it
    initial begin
        int k, c;
        logic [9:0] e;
        bus.op_done = 1'b0;
        bus.op_presence = 1'b0;
        bus.op_rdata = 8'h00;
        forever begin
            if (!pend) @(negedge clk);
            pend = 0;
            if (rst_n && bus.op_req) begin
                k = opn;
                opn++;
                if (opq.size() == 0) chk("spurious_op_req", 1, 0);
                else begin
                    e = opq.pop_front();
                    chk("op_code", 32'(bus.op_code), 32'(e[9:8]));
                    if (e[9:8] == 2'b01) chk("op_wdata", 32'(bus.op_wdata), 32'(e[7:0]));
                end
                if (k == rst_idx) rst_hit = 1;
                else if (k == hang_idx) begin
                    c = int'(f1m);
                    for (int i = 0; i < 4 * TOU; i++) begin
                        @(negedge clk);
                        if (bus_fault) break;
                        c += int'(f1m);
                    end
                    chk("timeout_strobes", c, TOU);
                end else begin
                    repeat ($urandom_range(1, 4)) @(posedge clk);
                    #1;
                    bus.op_done = 1'b1;
                    bus.op_presence = (k != np_idx);
                    bus.op_rdata = (k >= 22 && k <= 30) ? sp[k-22] : 8'($urandom);
                    @(posedge clk); #1;
                    bus.op_done = 1'b0;
                    bus.op_presence = 1'b0;
                    if (k == 10) begin
                        c = 0;
                        for (int i = 0; i < 10 * CWU; i++) begin
                            @(negedge clk);
                            if (bus.op_req) begin
                                pend = 1;
                                break;
                            end
                            c += int'(f1m);
                        end
                        chk("wait_strobes", c, CWU);
                    end
                end
            end
        end
    end

    // Outcome monitor: every pulse output is matched against the expected result queue
    initial forever begin
        ev_t ev;
        int kd;
        @(negedge clk);
        if (rst_n && (temp_valid || crc_err || no_presence || bus_fault)) begin
            chk("pulse_onehot", $countones({temp_valid, crc_err, no_presence, bus_fault}), 1);
            if (outq.size() == 0) chk("unexpected_pulse", 1, 0);
            else begin
                ev = outq.pop_front();
                kd = temp_valid ? 0 : crc_err ? 1 : no_presence ? 2 : 3;
                chk("outcome_kind", kd, ev.kind);
                if (temp_valid) chk("temp_dev", 32'(temp_dev), ev.dev);
                else chk("fault_device", 32'(device), ev.dev);
                if (temp_valid || crc_err) chk("temp_data", 32'(temp_data), 32'(ev.temp));
            end
        end
    end

    // One poll cycle: mode 0 random good, 1 reference scratchpad, 2 reference with bad CRC, 3 random bad CRC
    task automatic run_cycle(input int np_i, input int hang_i, input int rst_i, input int mode, input bit drop);
        logic [9:0] ops [$];
        int stop;
        ev_t ev;
        if (mode == 1 || mode == 2) sp = '{8'h50, 8'h05, 8'h4B, 8'h46, 8'h7F, 8'hFF, 8'h0C, 8'h10, 8'h1C};
        else begin
            for (int i = 0; i < 8; i++) sp[i] = 8'($urandom);
            sp[8] = crc_of(8);
        end
        if (mode == 2) sp[8] = 8'h1D;
        if (mode == 3) sp[8] = sp[8] ^ 8'($urandom_range(1, 255));
        ops = {10'h000, 10'h155};
        for (int i = 0; i < 8; i++) ops.push_back({2'b01, rom[mdev][i]});
        ops.push_back(10'h144);
        ops.push_back(10'h000);
        ops.push_back(10'h155);
        for (int i = 0; i < 8; i++) ops.push_back({2'b01, rom[mdev][i]});
        ops.push_back(10'h1BE);
        for (int i = 0; i < 9; i++) ops.push_back(10'h200);
        stop = (rst_i >= 0) ? rst_i : (np_i >= 0) ? np_i : (hang_i >= 0) ? hang_i : 30;
        np_idx = np_i;
        hang_idx = hang_i;
        rst_idx = rst_i;
        opn = 0;
        for (int i = 0; i <= stop; i++) opq.push_back(ops[i]);
        ev.dev = mdev;
        ev.temp = mlast;
        ev.kind = (np_i >= 0) ? 2 : (hang_i >= 0) ? 3 : (crc_of(9) == 8'h00) ? 0 : 1;
        if (ev.kind == 0) begin
            ev.temp = {sp[1], sp[0]};
            mlast = ev.temp;
        end
        if (rst_i < 0) begin
            outq.push_back(ev);
            mdev = (mdev + 1) % NDEV;
        end
        if (drop) begin
            for (int i = 0; i < 2000 && opn < 3; i++) @(negedge clk);
            @(posedge clk); #1 enable = 1'b0;
        end
        if (rst_i >= 0) begin
            for (int i = 0; i < 6000 && !rst_hit; i++) @(negedge clk);
            if (!rst_hit) begin
                chk("reset_point_reached", 0, 1);
                finish_now();
            end
            @(posedge clk); #1 rst_n = 1'b0;
            #1;
            chk("rst_op_req", 32'(bus.op_req), 0);
            chk("rst_device", 32'(device), 0);
            chk("rst_addr_idx", 32'(addr_idx), 0);
            chk("rst_temp_data", 32'(temp_data), 0);
            repeat (3) begin
                @(negedge clk);
                chk("rst_pulses", 32'({temp_valid, crc_err, no_presence, bus_fault, bus.op_req}), 0);
            end
            opq.delete();
            outq.delete();
            mdev = 0;
            mlast = 16'h0000;
            rst_hit = 0;
            @(posedge clk); #1 rst_n = 1'b1;
        end else begin
            for (int i = 0; i < 6000 && outq.size() != 0; i++) @(negedge clk);
            if (outq.size() != 0) begin
                chk("outcome_timeout", 0, 1);
                finish_now();
            end
            chk("ops_consumed", opq.size(), 0);
        end
    endtask

    initial begin
        int n, r;
        rom[0] = '{8'h28, 8'h92, 8'hD1, 8'h23, 8'h00, 8'h00, 8'h00, 8'hAA};
        for (int d = 1; d < 8; d++)
            for (int i = 0; i < 8; i++) rom[d][i] = 8'($urandom);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_state", 32'({bus.op_req, bus.op_code, bus.op_wdata, device, addr_idx, temp_dev}), 0);
        chk("reset_temp", 32'({temp_data, temp_valid, crc_err, no_presence, bus_fault}), 0);
        @(posedge clk); #1 rst_n = 1'b1;
        n = 0;
        repeat (10) begin
            @(negedge clk);
            n += int'(bus.op_req);
        end
        chk("disabled_no_req", n, 0);
        @(posedge clk); #1 enable = 1'b1;
        run_cycle(-1, -1, -1, 1, 0);
        run_cycle(-1, -1, -1, 2, 0);
        run_cycle(0, -1, -1, 0, 0);
        run_cycle(-1, 5, -1, 0, 0);
        repeat (5) run_cycle(-1, -1, -1, 0, 0);
        repeat (12) begin
            r = $urandom_range(0, 5);
            if (r == 0) run_cycle(0, -1, -1, 0, 0);
            else if (r == 1) run_cycle(11, -1, -1, 0, 0);
            else if (r == 2) run_cycle(-1, $urandom_range(0, 30), -1, 0, 0);
            else if (r == 3) run_cycle(-1, -1, -1, 3, 0);
            else run_cycle(-1, -1, -1, 0, 0);
        end
        while (mdev != 1) run_cycle(-1, -1, -1, 0, 0);
        run_cycle(-1, -1, 16, 0, 0);
        run_cycle(-1, -1, -1, 0, 0);
        run_cycle(-1, -1, -1, 0, 1);
        n = 0;
        repeat (100) begin
            @(negedge clk);
            n += int'(bus.op_req);
        end
        chk("parked_no_req", n, 0);
        chk("parked_device", 32'(device), mdev);
        finish_now();
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not complete");
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad + 1);
        $fatal(1);
    end
endmodule
